rv_thread_sched: RTL and testbench
==================================

Name: rv_thread_sched

Overview:
- Barrel-style hardware-thread scheduler and PC sequencer for the multithreaded RV core.
- Picks which thread issues next using round-robin, and holds the PC of every thread.
- Takes the branch-compare outcome (taken flag plus target) from the execute stage and updates the resolved thread's PC.
- Sits between thread spawn/wake control and the fetch stage. Each thread has at most one instruction in flight, so no intra-thread hazards exist.

Parameters:
- NTHREADS, 4, number of hardware threads (power of two, 2..8).
- TID_W, 2, thread-id width, equal to log2(NTHREADS).
- RESET_PC, 32'h0000_0000, start PC of thread 0 after reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- spawn_valid  in  1  request to start a thread.
- spawn_tid  in  TID_W  thread to start.
- spawn_pc  in  32  start PC for the spawned thread.
- issue_ready  in  1  fetch stage accepts an issue this cycle.
- issue_valid  out  1  an eligible thread is presented.
- issue_tid  out  TID_W  thread being issued.
- issue_pc  out  32  PC of the issued thread.
- resolve_valid  in  1  execute stage retires the in-flight instruction of resolve_tid.
- resolve_tid  in  TID_W  retiring thread.
- resolve_taken  in  1  branch/jump outcome from the comparator.
- resolve_target  in  32  redirect PC when taken.
- resolve_block  in  1  thread waits on an external event.
- resolve_halt  in  1  thread terminates.
- wake_valid  in  1  external event arrived.
- wake_tid  in  TID_W  thread to wake.
- active_mask  out  NTHREADS  bit t is set when thread t is not OFF.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: clk/rst_n, one clock, asynchronous active-low reset.
  - Thread 0 goes to RUN with pc=RESET_PC. Threads 1..N-1 go to OFF with pc=0.
  - rr_ptr=NTHREADS-1, err=0, active_mask=1.
  - issue_valid becomes 1 in the first cycle after reset deassertion (thread 0 eligible).
- Per-thread state: OFF, RUN, INFLIGHT, BLOCKED.
  - Encoded 2 bits per thread. Only RUN threads are issue-eligible.
- Issue selection (combinational from registered state):
  - Pick the first RUN thread scanning rr_ptr+1, rr_ptr+2, ..., wrapping modulo NTHREADS.
  - issue_valid=0 when no thread is in RUN.
  - issue_pc = pc[issue_tid].
- Issue handshake: when issue_valid && issue_ready, on that edge:
  - thread state RUN->INFLIGHT.
  - rr_ptr <= issue_tid.
  - When issue_ready=0, rr_ptr and states hold, and the presented selection stays stable.
- Resolve, when resolve_valid and the thread is INFLIGHT:
  - Next pc = resolve_taken ? {resolve_target[31:2],2'b00} : pc+4, with 32-bit wrap (FFFF_FFFC+4 = 0).
  - Next state priority: halt -> OFF; else block -> BLOCKED; else RUN.
  - pc is updated in all three cases.
  - The thread is issue-eligible in the cycle after the resolve edge.
- Wake: wake_valid on a BLOCKED thread -> RUN. Wake on any other state is ignored; no error is raised (early wakes are benign).
- Spawn: spawn_valid on an OFF thread -> RUN with pc=spawn_pc aligned to 4. Spawn on a non-OFF thread is ignored and sets err.
- Protocol errors: resolve_valid on a thread not in INFLIGHT is ignored and sets err. err clears only on reset.
- Simultaneous events in one cycle:
  - Events for distinct threads all apply independently.
  - For the same thread: resolve beats wake, and resolve beats spawn (the loser is ignored; a spawn loser sets err).
  - Issue and resolve of the same thread cannot coincide, because an INFLIGHT thread is not RUN.
  - Resolve of thread A together with issue of thread B: both apply.
- Reset mid-operation: all in-flight state is discarded immediately. Late resolves arriving after reset set err.
- active_mask is registered and reflects the state after each edge.

Optional Feature:
- RV_SCHED_PERF_EN.
- When defined:
  - Per-thread 32-bit issue counters cnt[t], incremented on each accepted issue of t, wrapping at 2^32. Cleared by reset.
  - Extra ports: perf_sel (in, TID_W) and perf_cnt (out, 32) = cnt[perf_sel], combinational.
- When undefined: no counters and no perf ports. Scheduling behaviour is identical.

Test Plan:
- Reset, issue_ready=1 -> cycle 1: issue_valid=1, tid=0, pc=0. Thread 0 then stays INFLIGHT with issue_valid=0 until resolve(tid0, taken=0) -> next issue pc=4.
- Spawn tid1 pc=0x100 and tid2 pc=0x200 with all threads resolving immediately, not taken -> issue order 0,1,2,0,1,2 with pcs 0x4/0x100/0x200/0x8/0x104/0x204.
- Resolve tid1 taken, target 0x1003 -> next issue of tid1 has pc=0x1000. Resolve taken=0 with pc=0xFFFF_FFFC -> pc=0.
- Resolve tid0 with block=1 -> tid0 skipped by round-robin. wake tid0 -> tid0 issued again at the pc resolved before blocking. resolve halt=1 -> active_mask bit0=0.
- issue_ready=0 for 5 cycles with threads 0,1 RUN -> issue_tid and issue_pc constant, no state change. Spawn of running tid0 -> err=1 and stays 1. Resolve of an OFF thread -> err=1.
- With RV_SCHED_PERF_EN, 10 issues of tid2 -> perf_sel=2 reads 10. Assert rst_n low mid-run -> all counters 0 and only tid0 in RUN.

Source files
------------

// File: rtl/rv_thread_sched_if.sv
// Issue/resolve/spawn/wake bundle between thread control, fetch, execute and rv_thread_sched.
// The scheduler takes the slave modport; the surrounding pipeline drives the master side.
interface rv_thread_sched_if #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TID_W    = 2
);

  logic                spawn_valid;
  logic [TID_W-1:0]    spawn_tid;
  logic [31:0]         spawn_pc;

  logic                issue_ready;
  logic                issue_valid;
  logic [TID_W-1:0]    issue_tid;
  logic [31:0]         issue_pc;

  logic                resolve_valid;
  logic [TID_W-1:0]    resolve_tid;
  logic                resolve_taken;
  logic [31:0]         resolve_target;
  logic                resolve_block;
  logic                resolve_halt;

  logic                wake_valid;
  logic [TID_W-1:0]    wake_tid;

  logic [NTHREADS-1:0] active_mask;
  logic                err;

  modport master (
    output spawn_valid, spawn_tid, spawn_pc,
    output issue_ready,
    input  issue_valid, issue_tid, issue_pc,
    output resolve_valid, resolve_tid, resolve_taken, resolve_target,
    output resolve_block, resolve_halt,
    output wake_valid, wake_tid,
    input  active_mask, err
  );

  modport slave (
    input  spawn_valid, spawn_tid, spawn_pc,
    input  issue_ready,
    output issue_valid, issue_tid, issue_pc,
    input  resolve_valid, resolve_tid, resolve_taken, resolve_target,
    input  resolve_block, resolve_halt,
    input  wake_valid, wake_tid,
    output active_mask, err
  );

endinterface

// File: rtl/rv_thread_sched.sv
// Round-robin hardware-thread scheduler and per-thread PC sequencer for the barrel RV core.
// Optional per-thread issue counters are built when RV_SCHED_PERF_EN is defined.
module rv_thread_sched #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TID_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  rv_thread_sched_if.slave sched
`ifdef RV_SCHED_PERF_EN
  ,
  input  logic [TID_W-1:0] perf_sel,
  output logic [31:0]      perf_cnt
`endif
);

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StRun      = 2'd1,
    StInflight = 2'd2,
    StBlocked  = 2'd3
  } th_state_e;

  th_state_e           state_q [NTHREADS];
  th_state_e           state_d [NTHREADS];
  logic [31:0]         pc_q    [NTHREADS];
  logic [31:0]         pc_d    [NTHREADS];
  logic [TID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;
  logic [NTHREADS-1:0] active_q, active_d;

  logic                sel_found;
  logic [TID_W-1:0]    sel_tid;
  logic [TID_W-1:0]    scan_idx;
  logic                issue_fire;

  logic [NTHREADS-1:0] res_hit;
  logic [NTHREADS-1:0] wake_hit;
  logic [NTHREADS-1:0] spawn_hit;
  logic [NTHREADS-1:0] issue_hit;

  logic [31:0]         spawn_pc_al;
  logic [31:0]         target_al;
  logic [31:0]         res_pc_next;
  th_state_e           res_state_next;

  assign spawn_pc_al = sched.spawn_pc & 32'hFFFF_FFFC;
  assign target_al   = sched.resolve_target & 32'hFFFF_FFFC;

  // Scan rr_ptr+1 .. rr_ptr+NTHREADS; the TID_W-bit add wraps modulo NTHREADS.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = '0;
    scan_idx  = '0;
    for (int unsigned i = 1; i <= NTHREADS; i++) begin
      scan_idx = rr_ptr_q + TID_W'(i);
      if (!sel_found && (state_q[scan_idx] == StRun)) begin
        sel_found = 1'b1;
        sel_tid   = scan_idx;
      end
    end
  end

  assign issue_fire        = sel_found & sched.issue_ready;
  assign sched.issue_valid = sel_found;
  assign sched.issue_tid   = sel_tid;
  assign sched.issue_pc    = pc_q[sel_tid];
  assign sched.active_mask = active_q;
  assign sched.err         = err_q;

  always_comb begin
    for (int unsigned t = 0; t < NTHREADS; t++) begin
      res_hit[t]   = sched.resolve_valid && (sched.resolve_tid == TID_W'(t));
      wake_hit[t]  = sched.wake_valid    && (sched.wake_tid    == TID_W'(t));
      spawn_hit[t] = sched.spawn_valid   && (sched.spawn_tid   == TID_W'(t));
      issue_hit[t] = issue_fire          && (sel_tid           == TID_W'(t));
    end
  end

  // Outcome of a legal resolve; only one thread resolves per cycle so it can be shared.
  always_comb begin
    res_pc_next = sched.resolve_taken ? target_al : (pc_q[sched.resolve_tid] + 32'd4);
    if (sched.resolve_halt) begin
      res_state_next = StOff;
    end else if (sched.resolve_block) begin
      res_state_next = StBlocked;
    end else begin
      res_state_next = StRun;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    active_d = '0;
    for (int unsigned t = 0; t < NTHREADS; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];
    end

    for (int unsigned t = 0; t < NTHREADS; t++) begin
      if (res_hit[t]) begin
        // Resolve wins over wake/spawn for the same thread; a losing spawn is still an error.
        if (state_q[t] == StInflight) begin
          pc_d[t]    = res_pc_next;
          state_d[t] = res_state_next;
        end else begin
          err_d = 1'b1;
        end
        if (spawn_hit[t]) begin
          err_d = 1'b1;
        end
      end else begin
        if (wake_hit[t] && (state_q[t] == StBlocked)) begin
          state_d[t] = StRun;
        end
        if (spawn_hit[t]) begin
          if (state_q[t] == StOff) begin
            state_d[t] = StRun;
            pc_d[t]    = spawn_pc_al;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Only RUN threads issue, and nothing above moves a RUN thread, so issue never conflicts.
      if (issue_hit[t]) begin
        state_d[t] = StInflight;
      end
      active_d[t] = (state_d[t] != StOff);
    end

    if (issue_fire) begin
      rr_ptr_d = sel_tid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        state_q[t] <= (t == 0) ? StRun : StOff;
        pc_q[t]    <= (t == 0) ? RESET_PC : 32'h0000_0000;
      end
      rr_ptr_q <= TID_W'(NTHREADS - 1);
      err_q    <= 1'b0;
      active_q <= NTHREADS'(1);
    end else begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        state_q[t] <= state_d[t];
        pc_q[t]    <= pc_d[t];
      end
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

`ifdef RV_SCHED_PERF_EN
  logic [31:0] cnt_q [NTHREADS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        cnt_q[t] <= 32'h0000_0000;
      end
    end else begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        if (issue_hit[t]) begin
          cnt_q[t] <= cnt_q[t] + 32'd1;
        end
      end
    end
  end

  assign perf_cnt = cnt_q[perf_sel];
`endif

endmodule

// File: tb/tb_rv_thread_sched.sv
// Self-checking bench for rv_thread_sched: directed scenarios plus randomized traffic
// against a thread-level reference model.
module tb_rv_thread_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rv_thread_sched_if #(.NTHREADS(N), .TID_W(TW)) bus ();

`ifdef RV_SCHED_PERF_EN
  logic [TW-1:0] perf_sel;
  logic [31:0]   perf_cnt;
`endif

  rv_thread_sched #(
    .NTHREADS(N),
    .TID_W   (TW),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sched(bus)
`ifdef RV_SCHED_PERF_EN
    ,
    .perf_sel(perf_sel),
    .perf_cnt(perf_cnt)
`endif
  );

  // Reference model: what each thread is doing, its PC, who issued last.
  typedef enum int {T_OFF, T_RUN, T_WAIT, T_BLK} tstate_e;

  tstate_e     m_st  [N];
  logic [31:0] m_pc  [N];
  logic [31:0] m_cnt [N];
  int          m_last;
  bit          m_err;

  int total = 0;
  int bad   = 0;

  function automatic int m_pick();
    for (int k = 1; k <= int'(N); k++) begin
      int t;
      t = (m_last + k) % int'(N);
      if (m_st[t] == T_RUN) return t;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    for (int i = 0; i < int'(N); i++) m[i] = (m_st[i] != T_OFF);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_st[i]  = (i == 0) ? T_RUN : T_OFF;
      m_pc[i]  = 32'h0;
      m_cnt[i] = 32'h0;
    end
    m_last = int'(N) - 1;
    m_err  = 1'b0;
  endtask

  // Apply the inputs currently driven to the model, as the coming clock edge will.
  task automatic model_edge();
    tstate_e st0 [N];
    int pick, rt, wt, sp;
    for (int i = 0; i < int'(N); i++) st0[i] = m_st[i];
    pick = m_pick();
    rt   = int'(bus.resolve_tid);
    wt   = int'(bus.wake_tid);
    sp   = int'(bus.spawn_tid);
    if (bus.resolve_valid) begin
      if (st0[rt] == T_WAIT) begin
        m_pc[rt] = bus.resolve_taken ? (bus.resolve_target & ~32'd3) : (m_pc[rt] + 32'd4);
        m_st[rt] = bus.resolve_halt ? T_OFF : (bus.resolve_block ? T_BLK : T_RUN);
      end else begin
        m_err = 1'b1;
      end
    end
    if (bus.wake_valid && !(bus.resolve_valid && wt == rt) && st0[wt] == T_BLK)
      m_st[wt] = T_RUN;
    if (bus.spawn_valid) begin
      if (bus.resolve_valid && sp == rt) m_err = 1'b1;
      else if (st0[sp] == T_OFF) begin
        m_st[sp] = T_RUN;
        m_pc[sp] = bus.spawn_pc & ~32'd3;
      end else m_err = 1'b1;
    end
    if (pick >= 0 && bus.issue_ready) begin
      m_st[pick]  = T_WAIT;
      m_last      = pick;
      m_cnt[pick] = m_cnt[pick] + 32'd1;
    end
  endtask

  task automatic idle();
    bus.spawn_valid    = 1'b0;
    bus.spawn_tid      = '0;
    bus.spawn_pc       = 32'h0;
    bus.issue_ready    = 1'b0;
    bus.resolve_valid  = 1'b0;
    bus.resolve_tid    = '0;
    bus.resolve_taken  = 1'b0;
    bus.resolve_target = 32'h0;
    bus.resolve_block  = 1'b0;
    bus.resolve_halt   = 1'b0;
    bus.wake_valid     = 1'b0;
    bus.wake_tid       = '0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.issue_valid !== 1'b1) begin bad++; $display("FAIL reset_valid got=%0b want=1", bus.issue_valid); end
    total++; if (bus.issue_tid !== TW'(0)) begin bad++; $display("FAIL reset_tid got=%0d want=0", bus.issue_tid); end
    total++; if (bus.issue_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.issue_pc); end
    total++; if (bus.active_mask !== 4'b0001) begin bad++; $display("FAIL reset_mask got=%b want=0001", bus.active_mask); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", bus.err); end
  endtask

  task automatic test_single();
    bus.issue_ready = 1'b1;
    cycle();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL single_inflight1 got=%0b want=0", bus.issue_valid); end
    cycle();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL single_inflight2 got=%0b want=0", bus.issue_valid); end
    bus.resolve_valid = 1'b1;
    bus.resolve_tid   = TW'(0);
    cycle();
    bus.resolve_valid = 1'b0;
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_tid !== TW'(0) || bus.issue_pc !== 32'h4) begin
      bad++; $display("FAIL single_next got=%0b/%0d/%h want=1/0/00000004",
                      bus.issue_valid, bus.issue_tid, bus.issue_pc);
    end
  endtask

  task automatic test_round_robin();
    int          exp_t [6] = '{0, 1, 2, 0, 1, 2};
    logic [31:0] exp_p [6] = '{32'h0, 32'h100, 32'h200, 32'h4, 32'h104, 32'h204};
    int prev = -1;
    do_reset();
    bus.spawn_valid = 1'b1; bus.spawn_tid = TW'(1); bus.spawn_pc = 32'h100;
    cycle();
    bus.spawn_tid = TW'(2); bus.spawn_pc = 32'h200;
    cycle();
    bus.spawn_valid = 1'b0;
    total++; if (bus.active_mask !== 4'b0111) begin bad++; $display("FAIL rr_mask got=%b want=0111", bus.active_mask); end
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (bus.issue_valid !== 1'b1 || bus.issue_tid !== TW'(exp_t[k]) || bus.issue_pc !== exp_p[k]) begin
        bad++; $display("FAIL rr_order[%0d] got=%0b/%0d/%h want=1/%0d/%h", k,
                        bus.issue_valid, bus.issue_tid, bus.issue_pc, exp_t[k], exp_p[k]);
      end
      bus.resolve_valid = (prev >= 0);
      bus.resolve_tid   = TW'(prev < 0 ? 0 : prev);
      cycle();
      prev = exp_t[k];
    end
    idle();
  endtask

  task automatic test_redirect();
    do_reset();
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(0);
    bus.resolve_taken = 1'b1; bus.resolve_target = 32'h1003;
    cycle();
    bus.resolve_valid = 1'b0;
    total++; if (bus.issue_pc !== 32'h1000) begin bad++; $display("FAIL redirect_pc got=%h want=00001000", bus.issue_pc); end
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_target = 32'hFFFF_FFFE;
    cycle();
    bus.resolve_valid = 1'b0;
    total++; if (bus.issue_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL redirect_top got=%h want=fffffffc", bus.issue_pc); end
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_taken = 1'b0;
    cycle();
    idle();
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h0) begin
      bad++; $display("FAIL pc_wrap got=%0b/%h want=1/00000000", bus.issue_valid, bus.issue_pc);
    end
  endtask

  task automatic test_block_wake_halt();
    do_reset();
    bus.spawn_valid = 1'b1; bus.spawn_tid = TW'(1); bus.spawn_pc = 32'h100;
    cycle();
    bus.spawn_valid = 1'b0;
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(0); bus.resolve_block = 1'b1;
    cycle();
    idle();
    total++; if (bus.issue_tid !== TW'(1) || bus.issue_pc !== 32'h100) begin
      bad++; $display("FAIL block_skip got=%0d/%h want=1/00000100", bus.issue_tid, bus.issue_pc); end
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(1);
    cycle();
    idle();
    total++; if (bus.issue_tid !== TW'(1) || bus.issue_pc !== 32'h104) begin
      bad++; $display("FAIL block_skip2 got=%0d/%h want=1/00000104", bus.issue_tid, bus.issue_pc); end
    total++; if (bus.active_mask !== 4'b0011) begin bad++; $display("FAIL block_mask got=%b want=0011", bus.active_mask); end
    bus.wake_valid = 1'b1; bus.wake_tid = TW'(0);
    cycle();
    idle();
    total++; if (bus.issue_tid !== TW'(0) || bus.issue_pc !== 32'h4) begin
      bad++; $display("FAIL wake_issue got=%0d/%h want=0/00000004", bus.issue_tid, bus.issue_pc); end
    bus.issue_ready = 1'b1;
    cycle();
    bus.issue_ready = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(0); bus.resolve_halt = 1'b1;
    cycle();
    idle();
    total++; if (bus.active_mask !== 4'b0010) begin bad++; $display("FAIL halt_mask got=%b want=0010", bus.active_mask); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL halt_err got=%0b want=0", bus.err); end
  endtask

  task automatic test_stall_and_errors();
    do_reset();
    bus.spawn_valid = 1'b1; bus.spawn_tid = TW'(1); bus.spawn_pc = 32'h100;
    cycle();
    bus.spawn_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bus.issue_valid !== 1'b1 || bus.issue_tid !== TW'(0) || bus.issue_pc !== 32'h0) begin
        bad++; $display("FAIL stall_hold[%0d] got=%0b/%0d/%h want=1/0/00000000", k,
                        bus.issue_valid, bus.issue_tid, bus.issue_pc);
      end
      cycle();
    end
    total++; if (bus.active_mask !== 4'b0011) begin bad++; $display("FAIL stall_mask got=%b want=0011", bus.active_mask); end
    bus.spawn_valid = 1'b1; bus.spawn_tid = TW'(0); bus.spawn_pc = 32'h40;
    cycle();
    bus.spawn_valid = 1'b0;
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL spawn_busy_err got=%0b want=1", bus.err); end
    total++; if (bus.issue_pc !== 32'h0) begin bad++; $display("FAIL spawn_busy_pc got=%h want=00000000", bus.issue_pc); end
    repeat (3) cycle();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", bus.err); end
    do_reset();
    bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(3);
    cycle();
    idle();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL resolve_off_err got=%0b want=1", bus.err); end
    total++; if (bus.active_mask !== 4'b0001) begin bad++; $display("FAIL resolve_off_mask got=%b want=0001", bus.active_mask); end
  endtask

  task automatic test_random(input int cycles, input bit legal);
    for (int c = 0; c < cycles; c++) begin
      int pick;
      int wl [$];
      logic [N-1:0] em;
      pick = m_pick();
      em   = m_mask();
      idle();
      total++;
      if (bus.issue_valid !== (pick >= 0) ||
          (pick >= 0 && (bus.issue_tid !== TW'(pick) || bus.issue_pc !== m_pc[pick]))) begin
        bad++; $display("FAIL rand_issue[%0d] got=%0b/%0d/%h want=%0b/%0d/%h", c, bus.issue_valid,
                        bus.issue_tid, bus.issue_pc, pick >= 0, pick, pick >= 0 ? m_pc[pick] : 32'h0);
      end
      total++;
      if (bus.active_mask !== em || bus.err !== m_err) begin
        bad++; $display("FAIL rand_status[%0d] got=%b/%0b want=%b/%0b", c,
                        bus.active_mask, bus.err, em, m_err);
      end
`ifdef RV_SCHED_PERF_EN
      perf_sel = TW'($urandom_range(0, N - 1));
      #0;
      total++;
      if (perf_cnt !== m_cnt[perf_sel]) begin
        bad++; $display("FAIL rand_perf[%0d] got=%0d want=%0d", c, perf_cnt, m_cnt[perf_sel]);
      end
`endif
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(N); i++) if (m_st[i] == T_WAIT) wl.push_back(i);
      if (legal) begin
        if (wl.size() > 0 && $urandom_range(0, 2) != 0) begin
          bus.resolve_valid = 1'b1;
          bus.resolve_tid   = TW'(wl[$urandom_range(0, wl.size() - 1)]);
        end
      end else begin
        bus.resolve_valid = ($urandom_range(0, 1) == 1);
        bus.resolve_tid   = TW'($urandom_range(0, N - 1));
      end
      bus.resolve_taken  = $urandom_range(0, 1) == 1;
      bus.resolve_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.resolve_block  = ($urandom_range(0, 7) == 0);
      bus.resolve_halt   = ($urandom_range(0, 9) == 0);
      bus.wake_valid     = ($urandom_range(0, 3) == 0);
      bus.wake_tid       = TW'($urandom_range(0, N - 1));
      bus.spawn_tid      = TW'($urandom_range(0, N - 1));
      bus.spawn_pc       = $urandom;
      bus.spawn_valid    = ($urandom_range(0, 4) == 0) &&
                           (!legal || m_st[int'(bus.spawn_tid)] == T_OFF);
      cycle();
    end
    idle();
  endtask

`ifdef RV_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    bus.issue_ready = 1'b1;
    bus.spawn_valid = 1'b1; bus.spawn_tid = TW'(2); bus.spawn_pc = 32'h200;
    cycle();
    bus.spawn_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.resolve_valid = 1'b0;
      cycle();
      bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(2);
      cycle();
    end
    idle();
    perf_sel = TW'(2);
    #1;
    total++; if (perf_cnt !== 32'd10) begin bad++; $display("FAIL perf_tid2 got=%0d want=10", perf_cnt); end
    perf_sel = TW'(0);
    #1;
    total++; if (perf_cnt !== 32'd1) begin bad++; $display("FAIL perf_tid0 got=%0d want=1", perf_cnt); end
  endtask
`endif

  // Asynchronous reset asserted between edges must clear everything without a clock.
  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    total++; if (bus.active_mask !== 4'b0001) begin bad++; $display("FAIL mid_reset_mask got=%b want=0001", bus.active_mask); end
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_tid !== TW'(0) || bus.issue_pc !== 32'h0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_issue got=%0b/%0d/%h/%0b want=1/0/00000000/0",
                      bus.issue_valid, bus.issue_tid, bus.issue_pc, bus.err);
    end
`ifdef RV_SCHED_PERF_EN
    for (int i = 0; i < int'(N); i++) begin
      perf_sel = TW'(i);
      #1;
      total++; if (perf_cnt !== 32'd0) begin bad++; $display("FAIL mid_reset_cnt[%0d] got=%0d want=0", i, perf_cnt); end
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resolve_valid = 1'b1; bus.resolve_tid = TW'(0);
    cycle();
    idle();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL late_resolve_err got=%0b want=1", bus.err); end
  endtask

  initial begin
    idle();
`ifdef RV_SCHED_PERF_EN
    perf_sel = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_redirect();
    test_block_wake_halt();
    test_stall_and_errors();
    do_reset();
    test_random(400, 1'b1);
    test_random(100, 1'b0);
`ifdef RV_SCHED_PERF_EN
    test_perf();
`endif
    test_random(50, 1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
